// File: rtl/gt_drp_fanout.sv
// gt_drp_fanout
// Fans one upstream DRP master out to PORTS downstream DRP slaves (GT channels
// plus common). The upper SEL_WIDTH address bits pick the port. The all-ones
// select broadcasts writes to every port when BCAST_EN is set. A broadcast
// read is served by port 0.
// Each transaction runs IDLE -> WAIT -> RESP -> IDLE. The upstream side sees
// exactly one s_drp_rdy pulse per accepted request. A request that waits more
// than TIMEOUT cycles, or that uses an invalid select, completes with
// s_drp_err set and data 16'hFFFF.
//
// Ports
//   clk, rst     : sole clock, synchronous active-high reset
//   s_drp_addr   : {select, address} from the upstream master
//   s_drp_di     : upstream write data
//   s_drp_do     : upstream read data, valid with s_drp_rdy
//   s_drp_en     : upstream request strobe
//   s_drp_we     : upstream write qualifier
//   s_drp_rdy    : one-cycle completion pulse
//   s_drp_err    : error flag, coincident with s_drp_rdy
//   busy         : a transaction is in flight
//   m_drp_*      : per-port DRP buses, packed as PORTS slices
module gt_drp_fanout #(
    parameter int PORTS      = 5,
    parameter int ADDR_WIDTH = 10,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 255,
    parameter int BCAST_EN   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEL_WIDTH+ADDR_WIDTH-1:0] s_drp_addr,
    input  logic [15:0]                   s_drp_di,
    output logic [15:0]                   s_drp_do,
    input  logic                          s_drp_en,
    input  logic                          s_drp_we,
    output logic                          s_drp_rdy,
    output logic                          s_drp_err,
    output logic                          busy,
    output logic [PORTS*ADDR_WIDTH-1:0]   m_drp_addr,
    output logic [PORTS*16-1:0]           m_drp_do,
    input  logic [PORTS*16-1:0]           m_drp_di,
    output logic [PORTS-1:0]              m_drp_en,
    output logic [PORTS-1:0]              m_drp_we,
    input  logic [PORTS-1:0]              m_drp_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [SEL_WIDTH-1:0] SEL_ALL = '1;

    state_t                 r_state;
    logic                   r_we;
    logic [SEL_WIDTH-1:0]   r_port;
    logic [PORTS-1:0]       r_target;
    logic [PORTS-1:0]       r_done;
    logic [15:0]            r_cnt;

    logic [SEL_WIDTH-1:0]   w_sel;
    logic [31:0]            w_sel32;
    logic                   w_bcast;
    logic                   w_invalid;
    logic [PORTS-1:0]       w_mask;
    logic [SEL_WIDTH-1:0]   w_port;
    logic [PORTS-1:0]       w_doneNext;
    logic                   w_allDone;
    logic                   w_expire;
    logic [15:0]            w_rdData;

    // Decode the incoming select into a target mask and a read-port index.
    // A broadcast read collapses to a plain read of port 0.
    always_comb begin
        w_sel     = s_drp_addr[SEL_WIDTH+ADDR_WIDTH-1 -: SEL_WIDTH];
        w_sel32   = 32'(w_sel);
        w_bcast   = (BCAST_EN != 0) && (w_sel == SEL_ALL);
        w_invalid = !w_bcast && (w_sel32 >= 32'(PORTS));
        w_port    = w_bcast ? '0 : w_sel;
        w_mask    = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (w_bcast) begin
                w_mask[i] = s_drp_we || (i == 0);
            end else begin
                w_mask[i] = (w_sel32 == 32'(i));
            end
        end
    end

    // Completion tracking in WAIT. Ready pulses from non-targeted ports are
    // masked off, and a pulse arriving this cycle already counts as done.
    // The read mux picks the selected port's data for capture on completion.
    always_comb begin
        w_doneNext = r_done | (m_drp_rdy & r_target);
        w_allDone  = ((w_doneNext & r_target) == r_target);
        w_expire   = (r_cnt == 16'(TIMEOUT - 1));
        w_rdData   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (32'(r_port) == 32'(i)) begin
                w_rdData = m_drp_di[i*16 +: 16];
            end
        end
    end

    // Transaction FSM. Every output is a register and is set up one cycle
    // ahead, on the transition into the state that presents it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_port     <= '0;
            r_target   <= '0;
            r_done     <= '0;
            r_cnt      <= '0;
            s_drp_do   <= '0;
            s_drp_rdy  <= 1'b0;
            s_drp_err  <= 1'b0;
            busy       <= 1'b0;
            m_drp_addr <= '0;
            m_drp_do   <= '0;
            m_drp_en   <= '0;
            m_drp_we   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_drp_en) begin
                        r_we       <= s_drp_we;
                        r_port     <= w_port;
                        r_done     <= '0;
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        m_drp_addr <= {PORTS{s_drp_addr[ADDR_WIDTH-1:0]}};
                        m_drp_do   <= {PORTS{s_drp_di}};
                        if (w_invalid) begin
                            // Nothing goes downstream; answer with an error next cycle.
                            r_target  <= '0;
                            r_state   <= RESP;
                            s_drp_rdy <= 1'b1;
                            s_drp_err <= 1'b1;
                            s_drp_do  <= 16'hFFFF;
                        end else begin
                            r_target  <= w_mask;
                            r_state   <= WAIT;
                            m_drp_en  <= w_mask;
                            m_drp_we  <= s_drp_we ? w_mask : '0;
                        end
                    end
                end
                WAIT: begin
                    m_drp_en <= '0;
                    m_drp_we <= '0;
                    r_done   <= w_doneNext;
                    r_cnt    <= r_cnt + 16'd1;
                    // Completion is tested before expiry so it wins a tie.
                    if (w_allDone) begin
                        r_state   <= RESP;
                        s_drp_rdy <= 1'b1;
                        s_drp_err <= 1'b0;
                        s_drp_do  <= r_we ? 16'h0000 : w_rdData;
                    end else if (w_expire) begin
                        r_state   <= RESP;
                        s_drp_rdy <= 1'b1;
                        s_drp_err <= 1'b1;
                        s_drp_do  <= 16'hFFFF;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    s_drp_rdy <= 1'b0;
                    s_drp_err <= 1'b0;
                    s_drp_do  <= '0;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gt_drp_fanout.sv
// tb_gt_drp_fanout
// Directed bench for gt_drp_fanout with PORTS=5, TIMEOUT=8. Each request is
// described at transaction level: select, data, and the per-port ready delay.
// From that, the bench works out arithmetically which ports are targeted,
// when the response lands, and what it carries. A negedge process compares
// every DUT output against those expectations each cycle. Literal checks
// after selected transactions pin the response cycle and payload.
module tb_gt_drp_fanout;

    localparam int PORTS = 5;
    localparam int AW    = 10;
    localparam int SW    = 4;
    localparam int TMO   = 8;
    localparam logic [7:0] NEVER = 8'hFF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SW+AW-1:0]     s_drp_addr;
    logic [15:0]          s_drp_di;
    logic [15:0]          s_drp_do;
    logic                 s_drp_en;
    logic                 s_drp_we;
    logic                 s_drp_rdy;
    logic                 s_drp_err;
    logic                 busy;
    logic [PORTS*AW-1:0]  m_drp_addr;
    logic [PORTS*16-1:0]  m_drp_do;
    logic [PORTS*16-1:0]  m_drp_di;
    logic [PORTS-1:0]     m_drp_en;
    logic [PORTS-1:0]     m_drp_we;
    logic [PORTS-1:0]     m_drp_rdy;

    int errors = 0;
    int checks = 0;

    bit              checkEn = 1'b0;
    int              relCyc  = 0;
    logic            expBusy, expRdy, expErr;
    logic [15:0]     expDo;
    logic [PORTS-1:0] expEn, expWe;
    logic [AW-1:0]   expAddr, lastAddr;
    logic [15:0]     expWd, lastWd;

    int              obsRdyRel, obsEnRel, obsRdyCount = 0, startCnt;
    logic [15:0]     obsDo;
    logic            obsErr;
    logic [PORTS-1:0] obsEnMask;

    gt_drp_fanout #(
        .PORTS(PORTS), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TMO), .BCAST_EN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_drp_addr(s_drp_addr), .s_drp_di(s_drp_di), .s_drp_do(s_drp_do),
        .s_drp_en(s_drp_en), .s_drp_we(s_drp_we), .s_drp_rdy(s_drp_rdy),
        .s_drp_err(s_drp_err), .busy(busy),
        .m_drp_addr(m_drp_addr), .m_drp_do(m_drp_do), .m_drp_di(m_drp_di),
        .m_drp_en(m_drp_en), .m_drp_we(m_drp_we), .m_drp_rdy(m_drp_rdy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the expectation set for this cycle, and
    // bookkeeping of what the DUT actually did for the literal checks.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy",       80'(busy),       80'(expBusy));
            checkOutput("s_drp_rdy",  80'(s_drp_rdy),  80'(expRdy));
            checkOutput("s_drp_err",  80'(s_drp_err),  80'(expErr));
            checkOutput("m_drp_en",   80'(m_drp_en),   80'(expEn));
            checkOutput("m_drp_we",   80'(m_drp_we),   80'(expWe));
            checkOutput("m_drp_addr", 80'(m_drp_addr), 80'({PORTS{expAddr}}));
            checkOutput("m_drp_do",   80'(m_drp_do),   80'({PORTS{expWd}}));
            if (expRdy) begin
                checkOutput("s_drp_do", 80'(s_drp_do), 80'(expDo));
            end
            if (s_drp_rdy === 1'b1) begin
                obsRdyRel = relCyc;
                obsDo     = s_drp_do;
                obsErr    = s_drp_err;
                obsRdyCount++;
            end
            if (m_drp_en !== '0) begin
                obsEnMask = obsEnMask | m_drp_en;
                obsEnRel  = relCyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        relCyc++;
    endtask

    task automatic setIdleExp();
        expBusy = 1'b0; expRdy = 1'b0; expErr = 1'b0; expDo = '0;
        expEn = '0; expWe = '0; expAddr = lastAddr; expWd = lastWd;
    endtask

    task automatic applyStimulus(input logic en, input logic [SW+AW-1:0] addr, input logic [15:0] di,
                                 input logic we, input logic [PORTS-1:0] rdy, input logic r);
        s_drp_en = en; s_drp_addr = addr; s_drp_di = di; s_drp_we = we;
        m_drp_rdy = rdy; rst = r;
    endtask

    task automatic clearObs();
        relCyc = 0; obsRdyRel = -1; obsEnRel = -1; obsEnMask = '0;
        obsDo = '0; obsErr = 1'b0; startCnt = obsRdyCount;
    endtask

    // One complete request. dly[i] is how many cycles after the m_drp_en
    // cycle port i pulses ready (NEVER = no pulse). Pulses on non-targeted
    // ports are still driven, so the DUT must ignore them.
    task automatic runTxn(input logic [SW-1:0] sel, input logic [AW-1:0] addr, input logic [15:0] wdata,
                          input logic we, input logic [PORTS-1:0][7:0] dly, input logic [79:0] di,
                          input int extraRel);
        bit bc, inv, never, err;
        logic [PORTS-1:0] tgt, rv;
        int rp, kDone, resp;
        logic [15:0] rdo;
        bc  = (sel == 4'hF);
        inv = !bc && (int'(sel) >= PORTS);
        tgt = inv ? '0 : (bc ? (we ? 5'h1F : 5'h01) : 5'(1 << sel));
        rp  = bc ? 0 : int'(sel);
        never = 1'b0; kDone = 0;
        for (int i = 0; i < PORTS; i++) begin
            if (tgt[i]) begin
                if (dly[i] == NEVER) never = 1'b1;
                else if (int'(dly[i]) + 1 > kDone) kDone = int'(dly[i]) + 1;
            end
        end
        if (inv) begin
            resp = 1; err = 1'b1; rdo = 16'hFFFF;
        end else if (!never && kDone <= TMO) begin
            resp = kDone + 1; err = 1'b0; rdo = we ? 16'h0000 : di[rp*16 +: 16];
        end else begin
            resp = TMO + 1; err = 1'b1; rdo = 16'hFFFF;
        end
        clearObs();
        m_drp_di = di;
        for (int r = 0; r <= resp + 1; r++) begin
            rv = '0;
            for (int i = 0; i < PORTS; i++) begin
                if (dly[i] != NEVER && int'(dly[i]) + 1 == r) rv[i] = 1'b1;
            end
            if (r == 0)             applyStimulus(1'b1, {sel, addr}, wdata, we, rv, 1'b0);
            else if (r == extraRel) applyStimulus(1'b1, {4'h3, 10'h3FF}, 16'hDEAD, 1'b1, rv, 1'b0);
            else                    applyStimulus(1'b0, '0, '0, 1'b0, rv, 1'b0);
            if (r == 0) begin
                setIdleExp();
            end else begin
                expAddr = addr; expWd = wdata;
                expBusy = (r <= resp);
                expEn   = (r == 1 && !inv) ? tgt : '0;
                expWe   = we ? expEn : '0;
                expRdy  = (r == resp);
                expErr  = expRdy && err;
                expDo   = rdo;
            end
            tick();
        end
        lastAddr = addr; lastWd = wdata;
        setIdleExp();
    endtask

    initial begin
        lastAddr = '0; lastWd = '0;
        m_drp_di = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        setIdleExp();
        tick();
        checkEn = 1'b1;
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();

        // Read of port 2, ready 3 cycles after the strobe; port 0 pulses stray ready.
        runTxn(4'h2, 10'h012, 16'h0000, 1'b0, {NEVER, NEVER, 8'd3, NEVER, 8'd1},
               {16'h4444, 16'h3333, 16'h1234, 16'h1111, 16'h0F0F}, -1);
        checkOutput("rd2_latency", 80'(obsRdyRel), 80'(5));
        checkOutput("rd2_data",    80'(obsDo),     80'(16'h1234));
        checkOutput("rd2_err",     80'(obsErr),    80'(0));
        checkOutput("rd2_enmask",  80'(obsEnMask), 80'(5'b00100));
        checkOutput("rd2_enrel",   80'(obsEnRel),  80'(1));

        // Broadcast write with staggered readies on cycles 2..6.
        runTxn(4'hF, 10'h07C, 16'hA5A5, 1'b1, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, '0, -1);
        checkOutput("bcw_enmask",  80'(obsEnMask), 80'(5'h1F));
        checkOutput("bcw_enrel",   80'(obsEnRel),  80'(1));
        checkOutput("bcw_latency", 80'(obsRdyRel), 80'(7));
        checkOutput("bcw_err",     80'(obsErr),    80'(0));
        checkOutput("bcw_data",    80'(obsDo),     80'(16'h0000));

        // Port 1 never answers: timeout after 8 WAIT cycles.
        runTxn(4'h1, 10'h201, 16'h0000, 1'b0, {NEVER, NEVER, NEVER, NEVER, NEVER},
               {16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111}, -1);
        checkOutput("tmo_latency", 80'(obsRdyRel), 80'(9));
        checkOutput("tmo_err",     80'(obsErr),    80'(1));
        checkOutput("tmo_data",    80'(obsDo),     80'(16'hFFFF));

        // Ready on the eighth WAIT cycle beats the timeout.
        runTxn(4'h1, 10'h202, 16'h0000, 1'b0, {NEVER, NEVER, NEVER, 8'd7, NEVER},
               {16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111}, -1);
        checkOutput("tie_latency", 80'(obsRdyRel), 80'(9));
        checkOutput("tie_err",     80'(obsErr),    80'(0));
        checkOutput("tie_data",    80'(obsDo),     80'(16'hBEEF));

        // Invalid select 4'hE and the boundary select 5.
        runTxn(4'hE, 10'h0AA, 16'h1357, 1'b1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, '0, -1);
        checkOutput("inv_latency", 80'(obsRdyRel), 80'(1));
        checkOutput("inv_err",     80'(obsErr),    80'(1));
        checkOutput("inv_enmask",  80'(obsEnMask), 80'(0));
        runTxn(4'h5, 10'h0AB, 16'h2468, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, '0, -1);
        checkOutput("sel5_err",    80'(obsErr),    80'(1));

        // Second request during WAIT, then one during RESP: both ignored.
        runTxn(4'h1, 10'h111, 16'h0000, 1'b0, {NEVER, NEVER, NEVER, 8'd4, NEVER},
               {16'h0005, 16'h0004, 16'h0003, 16'hC001, 16'h0001}, 2);
        checkOutput("xwait_count", 80'(obsRdyCount - startCnt), 80'(1));
        checkOutput("xwait_latency", 80'(obsRdyRel), 80'(6));
        runTxn(4'h0, 10'h3C0, 16'h7777, 1'b1, {NEVER, NEVER, NEVER, NEVER, 8'd0}, '0, 2);
        checkOutput("xresp_count", 80'(obsRdyCount - startCnt), 80'(1));

        // Broadcast read is a read of port 0; other ports pulse stray ready.
        runTxn(4'hF, 10'h055, 16'h0000, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd2},
               {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'hCAFE}, -1);
        checkOutput("bcr_data",    80'(obsDo),     80'(16'hCAFE));
        checkOutput("bcr_latency", 80'(obsRdyRel), 80'(4));
        checkOutput("bcr_enmask",  80'(obsEnMask), 80'(5'b00001));

        // Reset while waiting on port 3, followed by late and stray readies.
        clearObs();
        applyStimulus(1'b1, {4'h3, 10'h155}, 16'h0000, 1'b0, '0, 1'b0);
        setIdleExp();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        expBusy = 1'b1; expEn = 5'b01000; expAddr = 10'h155; expWd = 16'h0000;
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expEn = '0;
        tick();
        lastAddr = '0; lastWd = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, 5'b01000, 1'b0);
        setIdleExp();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 5'h1F, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("rst_no_rdy", 80'(obsRdyCount - startCnt), 80'(0));

        runTxn(4'h3, 10'h156, 16'h0000, 1'b0, {NEVER, 8'd1, NEVER, NEVER, NEVER},
               {16'h0000, 16'h9ABC, 16'h0000, 16'h0000, 16'h0000}, -1);
        checkOutput("post_rst_data",    80'(obsDo),     80'(16'h9ABC));
        checkOutput("post_rst_latency", 80'(obsRdyRel), 80'(3));

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
